// File: rtl/sd_pkg.sv
// Shared constants and types for the SD CMD-line response path.
package sd_pkg;

    typedef enum logic [2:0] {
        RespR1    = 3'd0,
        RespR2Cid = 3'd1,
        RespR2Csd = 3'd2,
        RespR3    = 3'd3,
        RespR6    = 3'd4,
        RespR7    = 3'd5
    } resp_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StWaitStart,
        StRecv,
        StCheck
    } state_e;

    localparam logic [6:0]  Crc7Poly      = 7'h09;
    localparam int unsigned FrameLenShort = 48;
    localparam int unsigned FrameLenLong  = 136;
    localparam logic [5:0]  R2Header      = 6'h3F;

    function automatic logic is_r2(input resp_type_e t);
        return (t == RespR2Cid) || (t == RespR2Csd);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), one update per enabled bit; clear wins over enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic       fb;

    assign fb = din_i ^ crc_q[6];

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_resp_receiver.sv
// Bit-serial SD response receiver: frames, checks and unpacks card responses
// and strobes the matching card-register load enable.
module sd_resp_receiver
    import sd_pkg::*;
#(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         bit_en_i,
    input  logic         cmd_in_i,
    input  logic         start_i,
    input  logic [2:0]   resp_type_i,
    input  logic [5:0]   exp_index_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_err_o,
    output logic         crc_err_o,
    output logic         frame_err_o,
    output logic         index_err_o,
    output logic [31:0]  resp_arg_o,
    output logic [127:0] cid_data_o,
    output logic [127:0] csd_data_o,
    output logic [31:0]  ocr_data_o,
    output logic [15:0]  rca_data_o,
    output logic         cid_en_o,
    output logic         csd_en_o,
    output logic         ocr_en_o,
    output logic         rca_en_o
);

    localparam int unsigned SlotW = $clog2(NCR_MAX + 1);

    state_e             state_q;
    resp_type_e         type_q;
    logic [5:0]         idx_q;
    logic [SlotW-1:0]   slot_q;
    logic [7:0]         cnt_q;
    logic [135:0]       sh_q;
    logic               busy_q, done_q;
    logic               timeout_q, crc_err_q, frame_err_q, index_err_q;
    logic [31:0]        arg_q, ocr_q;
    logic [127:0]       cid_q, csd_q;
    logic [15:0]        rca_q;
    logic               cid_en_q, csd_en_q, ocr_en_q, rca_en_q;

    logic [6:0]         crc;
    logic               r2;
    logic [7:0]         cnt_nxt, frame_len;
    logic [135:0]       sh_nxt;
    logic [SlotW-1:0]   slot_nxt;
    logic               accept, start_bit, recv_bit, crc_in_range, crc_en, crc_clr;
    logic               fe_chk, ce_chk, ie_chk, chk_ok;
    logic               unused_hdr;

    assign r2        = is_r2(type_q);
    assign cnt_nxt   = cnt_q + 8'd1;
    assign frame_len = r2 ? 8'(FrameLenLong) : 8'(FrameLenShort);
    assign sh_nxt    = {sh_q[134:0], cmd_in_i};
    assign slot_nxt  = slot_q + 1'b1;
    assign accept    = (state_q == StIdle) && start_i;
    assign start_bit = (state_q == StWaitStart) && bit_en_i && !cmd_in_i;
    assign recv_bit  = (state_q == StRecv) && bit_en_i;

    // cnt_nxt is the 1-based position of the bit being sampled; the start bit is position 1.
    assign crc_in_range = r2 ? ((cnt_nxt >= 8'd9) && (cnt_nxt <= 8'd128)) : (cnt_nxt <= 8'd40);
    assign crc_en       = start_bit || (recv_bit && crc_in_range);
    assign crc_clr      = accept || (recv_bit && r2 && (cnt_nxt == 8'd8));
    assign unused_hdr   = ^{sh_q[135], sh_nxt[135:134]};

    sd_crc7 u_crc7 (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (crc_clr),
        .en_i    (crc_en),
        .din_i   (cmd_in_i),
        .crc_o   (crc)
    );

    // Checks see the frame including the bit being sampled; the CRC has already stopped.
    always_comb begin
        fe_chk = 1'b0;
        ce_chk = 1'b0;
        ie_chk = 1'b0;
        if (r2) begin
            fe_chk = (sh_nxt[133:128] != R2Header) || !sh_nxt[0];
            ce_chk = (crc != sh_nxt[7:1]);
        end else begin
            fe_chk = sh_nxt[46] || !sh_nxt[0];
            if (type_q != RespR3) begin
                ie_chk = (sh_nxt[45:40] != idx_q);
                ce_chk = (crc != sh_nxt[7:1]);
            end
        end
        chk_ok = !(fe_chk || ce_chk || ie_chk);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            type_q      <= RespR1;
            idx_q       <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            sh_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_err_q <= 1'b0;
            arg_q       <= '0;
            ocr_q       <= '0;
            cid_q       <= '0;
            csd_q       <= '0;
            rca_q       <= '0;
            cid_en_q    <= 1'b0;
            csd_en_q    <= 1'b0;
            ocr_en_q    <= 1'b0;
            rca_en_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            cid_en_q <= 1'b0;
            csd_en_q <= 1'b0;
            ocr_en_q <= 1'b0;
            rca_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q     <= StWaitStart;
                        busy_q      <= 1'b1;
                        type_q      <= resp_type_e'(resp_type_i);
                        idx_q       <= exp_index_i;
                        slot_q      <= '0;
                        cnt_q       <= '0;
                        sh_q        <= '0;
                        timeout_q   <= 1'b0;
                        crc_err_q   <= 1'b0;
                        frame_err_q <= 1'b0;
                        index_err_q <= 1'b0;
                    end
                end
                StWaitStart: begin
                    if (bit_en_i) begin
                        if (!cmd_in_i) begin
                            state_q <= StRecv;
                            cnt_q   <= 8'd1;
                            sh_q    <= sh_nxt;
                        end else if (slot_nxt == SlotW'(NCR_MAX)) begin
                            state_q   <= StCheck;
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                        end else begin
                            slot_q <= slot_nxt;
                        end
                    end
                end
                StRecv: begin
                    if (bit_en_i) begin
                        sh_q  <= sh_nxt;
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == frame_len) begin
                            state_q     <= StCheck;
                            done_q      <= 1'b1;
                            frame_err_q <= fe_chk;
                            crc_err_q   <= ce_chk;
                            index_err_q <= ie_chk;
                            if (chk_ok) begin
                                if (!r2) begin
                                    arg_q <= sh_nxt[39:8];
                                end
                                case (type_q)
                                    RespR2Cid: begin
                                        cid_q    <= sh_nxt[127:0];
                                        cid_en_q <= 1'b1;
                                    end
                                    RespR2Csd: begin
                                        csd_q    <= sh_nxt[127:0];
                                        csd_en_q <= 1'b1;
                                    end
                                    RespR3: begin
                                        ocr_q    <= sh_nxt[39:8];
                                        ocr_en_q <= 1'b1;
                                    end
                                    RespR6: begin
                                        rca_q    <= sh_nxt[39:24];
                                        rca_en_q <= 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                StCheck: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_err_o = timeout_q;
    assign crc_err_o     = crc_err_q;
    assign frame_err_o   = frame_err_q;
    assign index_err_o   = index_err_q;
    assign resp_arg_o    = arg_q;
    assign cid_data_o    = cid_q;
    assign csd_data_o    = csd_q;
    assign ocr_data_o    = ocr_q;
    assign rca_data_o    = rca_q;
    assign cid_en_o      = cid_en_q;
    assign csd_en_o      = csd_en_q;
    assign ocr_en_o      = ocr_en_q;
    assign rca_en_o      = rca_en_q;

endmodule

// File: tb/tb_sd_resp_receiver.sv
// Directed plus randomized bench for sd_resp_receiver against a frame-level reference model.
module tb_sd_resp_receiver;

    logic         clk, reset, bit_en, cmd_in, start;
    logic [2:0]   resp_type;
    logic [5:0]   exp_index;
    logic         busy, done, timeout_err, crc_err, frame_err, index_err;
    logic [31:0]  resp_arg, ocr_data;
    logic [127:0] cid_data, csd_data;
    logic [15:0]  rca_data;
    logic         cid_en, csd_en, ocr_en, rca_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  m_arg, m_ocr;
    logic [127:0] m_cid, m_csd;
    logic [15:0]  m_rca;

    sd_resp_receiver #(.NCR_MAX(64)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .bit_en_i      (bit_en),
        .cmd_in_i      (cmd_in),
        .start_i       (start),
        .resp_type_i   (resp_type),
        .exp_index_i   (exp_index),
        .busy_o        (busy),
        .done_o        (done),
        .timeout_err_o (timeout_err),
        .crc_err_o     (crc_err),
        .frame_err_o   (frame_err),
        .index_err_o   (index_err),
        .resp_arg_o    (resp_arg),
        .cid_data_o    (cid_data),
        .csd_data_o    (csd_data),
        .ocr_data_o    (ocr_data),
        .rca_data_o    (rca_data),
        .cid_en_o      (cid_en),
        .csd_en_o      (csd_en),
        .ocr_en_o      (ocr_en),
        .rca_en_o      (rca_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC7 as polynomial division of v[hi:lo] by x^7+x^3+1.
    function automatic logic [6:0] crc7m(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [135:0] f48(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] v;
        v        = '0;
        v[47:8]  = {2'b00, idx, arg};
        v[7:1]   = crc7m(v, 47, 8);
        v[0]     = 1'b1;
        return v;
    endfunction

    function automatic logic [135:0] f136(input logic [119:0] body);
        logic [135:0] v;
        v          = '0;
        v[135:128] = {2'b00, 6'h3F};
        v[127:8]   = body;
        v[7:1]     = crc7m(v, 127, 8);
        v[0]       = 1'b1;
        return v;
    endfunction

    function automatic logic [135:0] f_r3(input logic [31:0] arg);
        logic [135:0] v;
        v      = '0;
        v[47:0] = {2'b00, 6'h3F, arg, 7'h7F, 1'b1};
        return v;
    endfunction

    task automatic chk_data(input string tag);
        chk({tag, "_arg"}, resp_arg, m_arg);
        chk({tag, "_cid"}, cid_data, m_cid);
        chk({tag, "_csd"}, csd_data, m_csd);
        chk({tag, "_ocr"}, ocr_data, m_ocr);
        chk({tag, "_rca"}, rca_data, m_rca);
    endtask

    task automatic run_frame(input string tag, input logic [2:0] rt, input logic [5:0] ei,
                             input logic [135:0] f, input int lead, input bit poke);
        bit         r2;
        int         n;
        logic       fe, ce, ie, ok;
        logic [3:0] en_exp;
        r2 = (rt == 3'd1) || (rt == 3'd2);
        n  = r2 ? 136 : 48;
        fe = 1'b0; ce = 1'b0; ie = 1'b0; en_exp = 4'b0000;
        if (r2) begin
            fe = (f[133:128] != 6'h3F) || (f[0] != 1'b1);
            ce = (crc7m(f, 127, 8) != f[7:1]);
        end else begin
            fe = (f[46] != 1'b0) || (f[0] != 1'b1);
            if (rt != 3'd3) begin
                ie = (f[45:40] != ei);
                ce = (crc7m(f, 47, 8) != f[7:1]);
            end
        end
        ok = !(fe || ce || ie);
        if (ok) begin
            case (rt)
                3'd1: begin m_cid = f[127:0]; en_exp = 4'b1000; end
                3'd2: begin m_csd = f[127:0]; en_exp = 4'b0100; end
                3'd3: begin m_ocr = f[39:8];  en_exp = 4'b0010; end
                3'd4: begin m_rca = f[39:24]; en_exp = 4'b0001; end
                default: ;
            endcase
            if (!r2) m_arg = f[39:8];
        end

        start = 1'b1; resp_type = rt; exp_index = ei;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_flags_clear"}, {timeout_err, crc_err, frame_err, index_err}, 0);
        for (int i = 0; i < lead; i++) begin
            bit_en = 1'b1; cmd_in = 1'b1;
            @(negedge clk);
            bit_en = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        for (int i = n - 1; i >= 0; i--) begin
            bit_en = 1'b1; cmd_in = f[i];
            if (poke && i == n / 2) begin
                start = 1'b1; resp_type = rt ^ 3'd1; exp_index = ~ei;
            end
            @(negedge clk);
            bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
            if (i == 1) chk({tag, "_no_early_done"}, done, 0);
            if (i > 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bit_en = 1'($urandom_range(0, 1));
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_in_check"}, busy, 1);
        chk({tag, "_flags"}, {timeout_err, crc_err, frame_err, index_err}, {1'b0, ce, fe, ie});
        chk({tag, "_enables"}, {cid_en, csd_en, ocr_en, rca_en}, en_exp);
        chk_data(tag);
        @(negedge clk);
        bit_en = 1'b0;
        chk({tag, "_done_fall"}, done, 0);
        chk({tag, "_en_fall"}, {cid_en, csd_en, ocr_en, rca_en}, 0);
        chk({tag, "_busy_fall"}, busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_status"}, {busy, done, timeout_err, crc_err, frame_err, index_err,
                               cid_en, csd_en, ocr_en, rca_en}, 0);
        chk_data(tag);
    endtask

    initial begin
        logic [135:0] f;
        logic [2:0]   rt;
        logic [5:0]   ei;
        logic [119:0] body;
        int           kind, pos;

        m_arg = '0; m_ocr = '0; m_cid = '0; m_csd = '0; m_rca = '0;
        reset = 1'b1; bit_en = 1'b0; cmd_in = 1'b1; start = 1'b0;
        resp_type = '0; exp_index = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        f = f48(6'd17, 32'h0000_0900);
        run_frame("r1_good", 3'd0, 6'd17, f, 2, 1'b0);
        f[7:1] = f[7:1] ^ 7'h01;
        run_frame("r1_badcrc", 3'd0, 6'd17, f, 0, 1'b0);
        run_frame("r1_badidx", 3'd0, 6'd18, f48(6'd17, 32'h0000_0900), 3, 1'b0);
        run_frame("r6", 3'd4, 6'd3, f48(6'd3, 32'hB368_0500), 1, 1'b0);
        run_frame("r3", 3'd3, 6'd41, f_r3(32'h80FF_8000), 4, 1'b0);
        body = {$urandom, $urandom, $urandom, $urandom};
        f = f136(body);
        run_frame("r2cid", 3'd1, 6'd2, f, 1, 1'b0);
        f[64] = ~f[64];
        run_frame("r2cid_flip64", 3'd1, 6'd2, f, 0, 1'b0);
        body = {$urandom, $urandom, $urandom, $urandom};
        run_frame("r2csd", 3'd2, 6'd9, f136(body), 2, 1'b1);
        run_frame("r7", 3'd5, 6'd8, f48(6'd8, $urandom), 0, 1'b1);
        f = f48(6'd13, $urandom);
        f[46] = 1'b1;
        run_frame("r1_txbit", 3'd0, 6'd13, f, 1, 1'b0);
        f = f48(6'd13, $urandom);
        f[0] = 1'b0;
        run_frame("r1_endbit", 3'd0, 6'd13, f, 1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            rt = 3'($urandom_range(0, 5));
            ei = 6'($urandom_range(0, 63));
            body = {$urandom, $urandom, $urandom, $urandom};
            if (rt == 3'd1 || rt == 3'd2) f = f136(body);
            else if (rt == 3'd3) f = f_r3($urandom);
            else f = f48(ei, $urandom);
            kind = $urandom_range(0, 4);
            if (kind == 1) begin
                pos = (rt == 3'd1 || rt == 3'd2) ? $urandom_range(0, 134) : $urandom_range(0, 46);
                f[pos] = ~f[pos];
            end else if (kind == 2) begin
                ei = ei ^ 6'($urandom_range(1, 63));
            end
            run_frame("rand", rt, ei, f, $urandom_range(0, 5), (k % 3) == 0);
        end

        // Timeout: 63 idle slots are tolerated, the 64th expires.
        start = 1'b1; resp_type = 3'd0; exp_index = 6'd1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 63; i++) begin
            bit_en = 1'b1; cmd_in = 1'b1;
            @(negedge clk);
            bit_en = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        chk("to_63_no_done", done, 0);
        chk("to_63_busy", busy, 1);
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        chk("to_done", done, 1);
        chk("to_flags", {timeout_err, crc_err, frame_err, index_err}, 4'b1000);
        chk("to_enables", {cid_en, csd_en, ocr_en, rca_en}, 0);
        @(negedge clk);
        chk("to_busy_fall", busy, 0);
        chk("to_sticky", timeout_err, 1);

        // Reset in the middle of an R1 frame.
        f = f48(6'd5, $urandom);
        start = 1'b1; resp_type = 3'd0; exp_index = 6'd5;
        @(negedge clk);
        start = 1'b0;
        chk("mid_timeout_cleared", timeout_err, 0);
        for (int i = 47; i > 27; i--) begin
            bit_en = 1'b1; cmd_in = f[i];
            @(negedge clk);
        end
        bit_en = 1'b0; cmd_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        m_arg = '0; m_ocr = '0; m_cid = '0; m_csd = '0; m_rca = '0;
        chk_all_zero("midreset");
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_beats_start", busy, 0);
        for (int i = 0; i < 5; i++) begin
            bit_en = 1'b1; cmd_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("post_reset_quiet", {busy, done}, 0);
        end
        bit_en = 1'b0; cmd_in = 1'b1;
        run_frame("after_reset", 3'd4, 6'd3, f48(6'd3, $urandom), 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
